// File: rtl/keccak_xif_sched.sv
// keccak_xif_sched: in-order X-interface offload queue that sequences committed Keccak instructions onto the core.
module keccak_xif_sched #(
  parameter int DEPTH     = 4,
  parameter int ID_W      = 4,
  parameter int NUM_WORDS = 50
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [ID_W-1:0] issue_id_i,
  input  logic [1:0]      issue_op_i,
  input  logic [5:0]      issue_addr_i,
  input  logic [31:0]     issue_data_i,
  input  logic            commit_valid_i,
  input  logic [ID_W-1:0] commit_id_i,
  input  logic            commit_kill_i,
  output logic            core_we_o,
  output logic [5:0]      core_addr_o,
  output logic [31:0]     core_wdata_o,
  input  logic [31:0]     core_rdata_i,
  output logic            core_start_o,
  input  logic            core_done_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [ID_W-1:0] result_id_o,
  output logic [31:0]     result_data_o,
  output logic            result_we_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [2:0] IDLE = 3'd0, EXEC = 3'd1, RDLAT = 3'd2, WAIT = 3'd3, RSP = 3'd4;
  localparam logic [1:0] OP_LOAD = 2'b00, OP_START = 2'b01, OP_READ = 2'b10;
  logic [2:0]      state;
  logic [ID_W-1:0] q_id   [DEPTH];
  logic [1:0]      q_op   [DEPTH];
  logic [5:0]      q_addr [DEPTH];
  logic [31:0]     q_data [DEPTH];
  logic [DEPTH-1:0] q_vld, q_cmt, q_kill;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [PW:0]     count;
  logic            push, pop, h_cmt, h_kill, h_go, in_range, rsp_set;
  logic [ID_W-1:0] h_id;
  logic [1:0]      h_op;
  logic [5:0]      h_addr;
  logic [31:0]     h_data;
  assign h_id     = q_id[rd_ptr];
  assign h_op     = q_op[rd_ptr];
  assign h_addr   = q_addr[rd_ptr];
  assign h_data   = q_data[rd_ptr];
  assign h_cmt    = q_vld[rd_ptr] && q_cmt[rd_ptr];
  assign h_kill   = q_kill[rd_ptr];
  assign h_go     = state == IDLE && h_cmt && !h_kill;
  assign in_range = int'(h_addr) < NUM_WORDS;
  assign issue_ready_o = !rst_i && count < (PW+1)'(DEPTH);
  assign push = issue_valid_i && issue_ready_o;
  assign pop  = (state == IDLE && h_cmt && h_kill) || (state == RSP && result_ready_i);
  // A result is produced on leaving EXEC (LOAD/reserved), RDLAT, or WAIT on done.
  assign rsp_set = (state == EXEC && h_op != OP_START && h_op != OP_READ) || state == RDLAT ||
                   (state == WAIT && core_done_i);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_vld  <= '0;
      q_cmt  <= '0;
      q_kill <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_id[wr_ptr]   <= issue_id_i;
        q_op[wr_ptr]   <= issue_op_i;
        q_addr[wr_ptr] <= issue_addr_i;
        q_data[wr_ptr] <= issue_data_i;
        q_vld[wr_ptr]  <= 1'b1;
        q_cmt[wr_ptr]  <= commit_valid_i && commit_id_i == issue_id_i;
        q_kill[wr_ptr] <= commit_valid_i && commit_id_i == issue_id_i && commit_kill_i;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      for (int i = 0; i < DEPTH; i++)
        if (commit_valid_i && q_vld[i] && q_id[i] == commit_id_i) begin
          q_cmt[i]  <= 1'b1;
          q_kill[i] <= q_kill[i] | commit_kill_i;
        end
      if (pop) begin
        q_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      core_we_o      <= 1'b0;
      core_addr_o    <= '0;
      core_wdata_o   <= '0;
      core_start_o   <= 1'b0;
      result_valid_o <= 1'b0;
      result_id_o    <= '0;
      result_data_o  <= '0;
      result_we_o    <= 1'b0;
    end else begin
      core_we_o    <= h_go && h_op == OP_LOAD && in_range;
      core_start_o <= h_go && h_op == OP_START;
      core_addr_o  <= h_go ? h_addr : '0;
      core_wdata_o <= h_go && h_op == OP_LOAD ? h_data : '0;
      case (state)
        IDLE:    state <= h_go ? EXEC : IDLE;
        EXEC:    state <= h_op == OP_START ? WAIT : h_op == OP_READ ? RDLAT : RSP;
        RDLAT:   state <= RSP;
        WAIT:    state <= core_done_i ? RSP : WAIT;
        RSP:     state <= result_ready_i ? IDLE : RSP;
        default: state <= IDLE;
      endcase
      if (rsp_set) begin
        result_valid_o <= 1'b1;
        result_id_o    <= h_id;
        result_we_o    <= h_op == OP_READ;
        result_data_o  <= state == RDLAT && in_range ? core_rdata_i : '0;
      end else if (state == RSP && result_ready_i) begin
        result_valid_o <= 1'b0;
        result_id_o    <= '0;
        result_we_o    <= 1'b0;
        result_data_o  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_keccak_xif_sched.sv
// tb_keccak_xif_sched: directed scenarios plus a randomized run scored against an in-order program model.
module tb_keccak_xif_sched;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        issue_valid_i = 1'b0, issue_ready_o;
  logic [3:0]  issue_id_i = '0;
  logic [1:0]  issue_op_i = '0;
  logic [5:0]  issue_addr_i = '0;
  logic [31:0] issue_data_i = '0;
  logic        commit_valid_i = 1'b0, commit_kill_i = 1'b0;
  logic [3:0]  commit_id_i = '0;
  logic        core_we_o, core_start_o, core_done_i, result_valid_o, result_we_o;
  logic [5:0]  core_addr_o;
  logic [31:0] core_wdata_o, core_rdata_i, result_data_o;
  logic        result_ready_i = 1'b1;
  logic [3:0]  result_id_o;
  typedef struct packed {logic [3:0] id; logic [31:0] data; logic we;} res_t;
  res_t        res_q[$], exp_q[$];
  logic [31:0] mem [64];
  logic [31:0] mdl_mem [64];
  int          pass_cnt = 0, total_cnt = 0, wr_cnt = 0, start_cnt = 0;
  int          done_cnt = 0, done_lat = 24;
  bit          done_en = 1'b1, done_req = 1'b0, rnd_rdy = 1'b0;
  always #5 clk_i = ~clk_i;
  keccak_xif_sched dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_id_i(issue_id_i),
    .issue_op_i(issue_op_i), .issue_addr_i(issue_addr_i), .issue_data_i(issue_data_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .core_we_o(core_we_o), .core_addr_o(core_addr_o), .core_wdata_o(core_wdata_o),
    .core_rdata_i(core_rdata_i), .core_start_o(core_start_o), .core_done_i(core_done_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_id_o(result_id_o),
    .result_data_o(result_data_o), .result_we_o(result_we_o)
  );
  // Stub core: word array with 1-cycle read, done pulse done_lat cycles after start.
  always @(posedge clk_i) begin
    if (core_we_o) mem[core_addr_o] <= core_wdata_o;
    core_rdata_i <= mem[core_addr_o];
    core_done_i  <= done_req || done_cnt == 1;
    if (core_start_o && done_en) done_cnt <= done_lat;
    else if (done_cnt > 0) done_cnt <= done_cnt - 1;
  end
  always @(negedge clk_i) begin
    if (core_we_o) wr_cnt++;
    if (core_start_o) start_cnt++;
    if (result_valid_o && result_ready_i) res_q.push_back('{result_id_o, result_data_o, result_we_o});
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk_i);
    #1;
    if (rnd_rdy) result_ready_i = 1'($urandom_range(0, 1));
  endtask
  // cmt: 0 = no commit, 1 = commit and 2 = kill in the push cycle
  task automatic do_issue(input logic [3:0] id, input logic [1:0] op, input logic [5:0] a,
                          input logic [31:0] d, input int cmt);
    int n = 0;
    issue_valid_i = 1'b1; issue_id_i = id; issue_op_i = op; issue_addr_i = a; issue_data_i = d;
    while (!issue_ready_o && n < 200) begin tick(); n++; end
    if (n >= 200) begin total_cnt++; $display("FAIL issue_timeout id=%0d ready=%0b exp=1", id, issue_ready_o); end
    commit_valid_i = cmt != 0; commit_id_i = id; commit_kill_i = cmt == 2;
    tick();
    issue_valid_i = 1'b0; commit_valid_i = 1'b0; commit_kill_i = 1'b0;
  endtask
  task automatic do_commit(input logic [3:0] id, input bit kill);
    commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
    tick();
    commit_valid_i = 1'b0; commit_kill_i = 1'b0;
  endtask
  task automatic model(input logic [3:0] id, input logic [1:0] op, input logic [5:0] a,
                       input logic [31:0] d, input bit kill);
    if (kill) return;
    if (op == 2'b00 && a < 6'd50) mdl_mem[a] = d;
    exp_q.push_back('{id, (op == 2'b10 && a < 6'd50) ? mdl_mem[a] : 32'h0, op == 2'b10});
  endtask
  task automatic test_reset();
    repeat (3) tick();
    total_cnt++; if ({core_we_o, core_addr_o, core_wdata_o, core_start_o, result_valid_o, result_id_o, result_data_o, result_we_o} !== '0)
      $display("FAIL reset_outputs got nonzero exp=0"); else pass_cnt++;
    rst_i = 1'b0;
    tick();
    total_cnt++; if (issue_ready_o !== 1'b1) $display("FAIL reset_ready got=%0b exp=1", issue_ready_o); else pass_cnt++;
  endtask
  task automatic test_load();
    do_issue(4'd1, 2'b00, 6'd3, 32'hDEADBEEF, 0);
    do_commit(4'd1, 1'b0);
    total_cnt++; if (core_we_o !== 1'b0) $display("FAIL load_we_early got=%0b exp=0", core_we_o); else pass_cnt++;
    tick();
    total_cnt++; if ({core_we_o, core_addr_o, core_wdata_o} !== {1'b1, 6'd3, 32'hDEADBEEF})
      $display("FAIL load_write got=%0b/%0d/%h exp=1/3/deadbeef", core_we_o, core_addr_o, core_wdata_o); else pass_cnt++;
    total_cnt++; if (result_valid_o !== 1'b0) $display("FAIL load_valid_early got=%0b exp=0", result_valid_o); else pass_cnt++;
    tick();
    total_cnt++; if ({core_we_o, result_valid_o, result_id_o, result_we_o, result_data_o} !== {1'b0, 1'b1, 4'd1, 1'b0, 32'h0})
      $display("FAIL load_result got=we%0b v%0b id%0d we%0b %h exp=we0 v1 id1 we0 0", core_we_o, result_valid_o, result_id_o, result_we_o, result_data_o); else pass_cnt++;
    tick();
    total_cnt++; if (result_valid_o !== 1'b0) $display("FAIL load_valid_drop got=%0b exp=0", result_valid_o); else pass_cnt++;
  endtask
  task automatic test_read();
    do_issue(4'd2, 2'b10, 6'd3, 32'h0, 0);
    do_commit(4'd2, 1'b0);
    tick();
    total_cnt++; if ({core_we_o, core_addr_o} !== {1'b0, 6'd3}) $display("FAIL read_addr got=%0b/%0d exp=0/3", core_we_o, core_addr_o); else pass_cnt++;
    tick();
    total_cnt++; if (result_valid_o !== 1'b0) $display("FAIL read_valid_early got=%0b exp=0", result_valid_o); else pass_cnt++;
    tick();
    total_cnt++; if ({result_valid_o, result_id_o, result_we_o, result_data_o} !== {1'b1, 4'd2, 1'b1, 32'hDEADBEEF})
      $display("FAIL read_result got=v%0b id%0d we%0b %h exp=v1 id2 we1 deadbeef", result_valid_o, result_id_o, result_we_o, result_data_o); else pass_cnt++;
    tick();
  endtask
  task automatic test_start();
    int s0 = start_cnt, n = 0;
    done_lat = 24;
    do_issue(4'd3, 2'b01, 6'd0, 32'h0, 0);
    do_commit(4'd3, 1'b0);
    tick();
    total_cnt++; if (core_start_o !== 1'b1) $display("FAIL start_pulse got=%0b exp=1", core_start_o); else pass_cnt++;
    tick();
    total_cnt++; if (core_start_o !== 1'b0) $display("FAIL start_pulse_end got=%0b exp=0", core_start_o); else pass_cnt++;
    total_cnt++; if (issue_ready_o !== 1'b1) $display("FAIL start_issue_ready got=%0b exp=1", issue_ready_o); else pass_cnt++;
    do_issue(4'd4, 2'b00, 6'd5, 32'h12345678, 0);
    while (!core_done_i && n < 100) begin tick(); n++; end
    if (n >= 100) begin total_cnt++; $display("FAIL start_done_timeout got=0 exp=1"); end
    total_cnt++; if (result_valid_o !== 1'b0) $display("FAIL start_valid_early got=%0b exp=0", result_valid_o); else pass_cnt++;
    tick();
    total_cnt++; if ({result_valid_o, result_id_o, result_we_o} !== {1'b1, 4'd3, 1'b0})
      $display("FAIL start_result got=v%0b id%0d we%0b exp=v1 id3 we0", result_valid_o, result_id_o, result_we_o); else pass_cnt++;
    do_commit(4'd4, 1'b0);
    repeat (8) tick();
    total_cnt++; if (start_cnt - s0 != 1) $display("FAIL start_count got=%0d exp=1", start_cnt - s0); else pass_cnt++;
    total_cnt++; if (mem[5] !== 32'h12345678) $display("FAIL start_queued_load got=%h exp=12345678", mem[5]); else pass_cnt++;
  endtask
  task automatic test_full_kill();
    int r0 = res_q.size();
    for (int i = 8; i < 12; i++) do_issue(4'(i), 2'b00, 6'(20 + i), $urandom, 0);
    total_cnt++; if (issue_ready_o !== 1'b0) $display("FAIL full_ready got=%0b exp=0", issue_ready_o); else pass_cnt++;
    do_commit(4'd8, 1'b1);
    total_cnt++; if (issue_ready_o !== 1'b0) $display("FAIL kill_ready_same got=%0b exp=0", issue_ready_o); else pass_cnt++;
    tick();
    total_cnt++; if (issue_ready_o !== 1'b1) $display("FAIL kill_ready_next got=%0b exp=1", issue_ready_o); else pass_cnt++;
    do_commit(4'd9, 1'b1);
    do_commit(4'd10, 1'b0);
    do_commit(4'd11, 1'b0);
    repeat (12) tick();
    total_cnt++; if (res_q.size() - r0 != 2) $display("FAIL kill_result_count got=%0d exp=2", res_q.size() - r0);
    else if (res_q[r0].id !== 4'd10 || res_q[r0+1].id !== 4'd11) $display("FAIL kill_result_ids got=%0d,%0d exp=10,11", res_q[r0].id, res_q[r0+1].id);
    else pass_cnt++;
  endtask
  task automatic test_out_of_order();
    int r0 = res_q.size();
    logic [31:0] d = $urandom;
    do_issue(4'd5, 2'b00, 6'd10, d, 0);
    do_issue(4'd6, 2'b10, 6'd10, 32'h0, 0);
    do_commit(4'd6, 1'b0);
    repeat (5) tick();
    total_cnt++; if (res_q.size() != r0) $display("FAIL ooo_blocked got=%0d exp=0", res_q.size() - r0); else pass_cnt++;
    do_commit(4'd5, 1'b0);
    repeat (12) tick();
    total_cnt++; if (res_q.size() - r0 != 2) $display("FAIL ooo_count got=%0d exp=2", res_q.size() - r0);
    else if (res_q[r0] !== '{4'd5, 32'h0, 1'b0} || res_q[r0+1] !== '{4'd6, d, 1'b1})
      $display("FAIL ooo_order got=%0d/%0d data=%h exp=5/6 data=%h", res_q[r0].id, res_q[r0+1].id, res_q[r0+1].data, d);
    else pass_cnt++;
  endtask
  task automatic test_boundary();
    int r0 = res_q.size(), w0 = wr_cnt;
    do_issue(4'd7, 2'b00, 6'd55, $urandom, 1);
    do_issue(4'd15, 2'b10, 6'd60, 32'h0, 1);
    do_issue(4'd0, 2'b11, 6'd4, $urandom, 1);
    repeat (15) tick();
    total_cnt++; if (wr_cnt != w0) $display("FAIL bound_no_write got=%0d exp=0", wr_cnt - w0); else pass_cnt++;
    total_cnt++; if (res_q.size() - r0 != 3) $display("FAIL bound_count got=%0d exp=3", res_q.size() - r0);
    else if (res_q[r0] !== '{4'd7, 32'h0, 1'b0} || res_q[r0+1] !== '{4'd15, 32'h0, 1'b1} || res_q[r0+2] !== '{4'd0, 32'h0, 1'b0})
      $display("FAIL bound_results got=%h %h %h exp=7/0/0 f/0/1 0/0/0", res_q[r0], res_q[r0+1], res_q[r0+2]);
    else pass_cnt++;
  endtask
  task automatic test_backpressure();
    int n = 0;
    result_ready_i = 1'b0;
    do_issue(4'd12, 2'b10, 6'd3, 32'h0, 1);
    while (!result_valid_o && n < 20) begin tick(); n++; end
    if (n >= 20) begin total_cnt++; $display("FAIL bp_timeout got=0 exp=1"); end
    for (int i = 0; i < 10; i++) begin
      total_cnt++; if ({result_valid_o, result_id_o, result_data_o, result_we_o} !== {1'b1, 4'd12, 32'hDEADBEEF, 1'b1})
        $display("FAIL bp_stable cyc=%0d got=v%0b id%0d %h we%0b exp=v1 id12 deadbeef we1", i, result_valid_o, result_id_o, result_data_o, result_we_o); else pass_cnt++;
      tick();
    end
    result_ready_i = 1'b1;
    tick();
    total_cnt++; if (result_valid_o !== 1'b0) $display("FAIL bp_release got=%0b exp=0", result_valid_o); else pass_cnt++;
  endtask
  task automatic test_reset_wait();
    int n = 0, r0, w0;
    done_en = 1'b0;
    do_issue(4'd13, 2'b01, 6'd0, 32'h0, 1);
    do_issue(4'd14, 2'b00, 6'd7, $urandom, 0);
    while (!core_start_o && n < 20) begin tick(); n++; end
    if (n >= 20) begin total_cnt++; $display("FAIL rw_start_timeout got=0 exp=1"); end
    repeat (3) tick();
    rst_i = 1'b1;
    tick();
    total_cnt++; if ({core_we_o, core_addr_o, core_wdata_o, core_start_o, result_valid_o, result_id_o, result_data_o, result_we_o} !== '0)
      $display("FAIL rw_outputs got nonzero exp=0"); else pass_cnt++;
    rst_i = 1'b0;
    #1;
    total_cnt++; if (issue_ready_o !== 1'b1) $display("FAIL rw_ready got=%0b exp=1", issue_ready_o); else pass_cnt++;
    r0 = res_q.size(); w0 = wr_cnt;
    do_commit(4'd14, 1'b0);
    done_req = 1'b1;
    tick();
    done_req = 1'b0;
    repeat (10) tick();
    total_cnt++; if (res_q.size() != r0 || result_valid_o !== 1'b0 || wr_cnt != w0)
      $display("FAIL rw_no_result got=%0d results %0d writes exp=0 0", res_q.size() - r0, wr_cnt - w0); else pass_cnt++;
    done_en = 1'b1;
  endtask
  task automatic test_random();
    logic [3:0]  nid = '0;
    logic [3:0]  pid[$];
    bit          pk[$];
    logic [1:0]  op;
    logic [5:0]  a;
    logic [31:0] d;
    bit          kill, same;
    int          n = 0, k;
    res_q.delete(); exp_q.delete();
    rnd_rdy = 1'b1;
    for (int i = 0; i < 50; i++) begin
      d = $urandom;
      do_issue(nid, 2'b00, 6'(i), d, 1);
      model(nid, 2'b00, 6'(i), d, 1'b0);
      nid++;
    end
    repeat (25) begin
      done_lat = $urandom_range(1, 8);
      repeat ($urandom_range(1, 3)) begin
        op = 2'($urandom_range(0, 3)); a = 6'($urandom_range(0, 55)); d = $urandom;
        kill = $urandom_range(0, 9) < 2; same = $urandom_range(0, 2) == 0;
        do_issue(nid, op, a, d, same ? (kill ? 2 : 1) : 0);
        model(nid, op, a, d, kill);
        if (!same) begin pid.push_back(nid); pk.push_back(kill); end
        nid++;
      end
      while (pid.size() > 0) begin
        k = $urandom_range(0, pid.size() - 1);
        do_commit(pid[k], pk[k]);
        pid.delete(k); pk.delete(k);
      end
    end
    while (res_q.size() < exp_q.size() && n < 3000) begin tick(); n++; end
    rnd_rdy = 1'b0; result_ready_i = 1'b1;
    repeat (5) tick();
    total_cnt++; if (res_q.size() != exp_q.size()) $display("FAIL rand_count got=%0d exp=%0d", res_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < res_q.size(); i++) begin
      total_cnt++; if (res_q[i] !== exp_q[i])
        $display("FAIL rand_result idx=%0d got=id%0d %h we%0b exp=id%0d %h we%0b", i, res_q[i].id, res_q[i].data, res_q[i].we, exp_q[i].id, exp_q[i].data, exp_q[i].we);
      else pass_cnt++;
    end
  endtask
  initial begin
    test_reset();
    test_load();
    test_read();
    test_start();
    test_full_kill();
    test_out_of_order();
    test_boundary();
    test_backpressure();
    test_reset_wait();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/keccak_xif_sched.md
Name: keccak_xif_sched

Overview:
- In-order scheduler between the X-interface offload path and the Keccak-f[1600] core.
- Buffers offloaded Keccak instructions and holds each one until its commit or kill arrives.
- Sequences committed instructions onto the core: state-word writes, permutation start and done wait, state-word reads.
- Returns exactly one result per committed instruction over a valid/ready result channel.

Parameters:
DEPTH, 4, instruction queue entries (power of 2, ≥2)
ID_W, 4, instruction ID width
NUM_WORDS, 50, 32-bit words in the 1600-bit state

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
issue_valid_i  in  1  offloaded instruction valid
issue_ready_o  out  1  queue can accept
issue_id_i  in  ID_W  instruction ID
issue_op_i  in  2  00 LOAD word, 01 START permutation, 10 READ word, 11 reserved (treated as LOAD to ignored address)
issue_addr_i  in  6  state word index
issue_data_i  in  32  LOAD data (rs1)
commit_valid_i  in  1  commit event
commit_id_i  in  ID_W  committed ID
commit_kill_i  in  1  1 = discard instruction
core_we_o  out  1  state word write strobe
core_addr_o  out  6  state word index
core_wdata_o  out  32  write data
core_rdata_i  in  32  read data, 1-cycle latency after core_addr_o
core_start_o  out  1  one-cycle permutation start pulse
core_done_i  in  1  one-cycle permutation done pulse
result_valid_o  out  1  result valid
result_ready_i  in  1  result accepted
result_id_o  out  ID_W  result ID
result_data_o  out  32  READ data, else 0
result_we_o  out  1  1 only for READ (rd writeback)

Behaviour:
- Reset: queue empty, FSM IDLE. All outputs 0, except issue_ready_o = 1 once reset is released. Reset mid-permutation returns to IDLE and drops all entries; the core's state array is not cleared.
- Queue:
  - Circular FIFO with rd_ptr, wr_ptr and count.
  - Each entry holds {id, op, addr, data, committed, killed}.
  - issue_ready_o = (count < DEPTH). No same-cycle pop bypass, so when full, issue_ready_o stays 0 in the pop cycle.
  - Push on issue_valid_i & issue_ready_o.
- Commit:
  - Sets committed (and killed if commit_kill_i) on every valid entry whose id matches.
  - A commit in the same cycle as the push of that ID is applied to the new entry.
  - A commit for an unknown ID is ignored.
- FSM states: IDLE, EXEC, RDLAT, WAIT, RSP.
  - IDLE, head not committed (or queue empty): stay.
  - IDLE, head committed & killed: pop the head that cycle, no core access, no result, stay IDLE.
  - IDLE, head committed & not killed: go to EXEC.
  - EXEC, LOAD: drive core_we_o=1, core_addr_o, core_wdata_o for exactly one cycle, then go to RSP. Addresses ≥ NUM_WORDS suppress core_we_o.
  - EXEC, START: core_start_o=1 for exactly one cycle, then go to WAIT.
  - EXEC, READ: drive core_addr_o, then go to RDLAT.
  - RDLAT: capture core_rdata_i (forced to 0 if addr ≥ NUM_WORDS), then go to RSP.
  - WAIT: stay until core_done_i=1, then go to RSP. core_done_i outside WAIT is ignored.
  - RSP: result_valid_o=1 with id/data/we stable until result_ready_i. On accept, pop the head and return to IDLE. The earliest next EXEC is the cycle after.
- Latency, commit already present at head:
  - LOAD: result_valid_o asserts 2 cycles after head reaches IDLE.
  - READ: 3 cycles.
  - START: 3 cycles plus core latency.
- Issue and commit remain accepted in every FSM state.
- Outputs are registered except issue_ready_o.

Test Plan:
- Reset, then issue LOAD id=1 addr=3 data=0xDEADBEEF, commit id=1 → core_we_o pulse with addr 3 and that data; result id=1, we=0, data=0.
- Issue READ id=2 addr=3, commit, core_rdata_i=0xDEADBEEF one cycle after addr → result id=2, we=1, data=0xDEADBEEF.
- START id=3 committed, core_done_i after 24 cycles → single core_start_o pulse; result id=3 follows done by 1 cycle; issue of id=4 accepted while waiting.
- Fill 4 entries uncommitted → issue_ready_o=0. Kill id of head → popped with no result, issue_ready_o=1 next cycle.
- Commit arrives before the head commit (out of order: commit id=6 then id=5) → execution and results stay in queue order 5, 6.
- result_ready_i held 0 for 10 cycles → result_valid_o and fields stable. Assert rst_i during WAIT → all outputs 0 next cycle, queue empty; a later core_done_i causes no result.
